// File: rtl/c499_key_seq_ctrl.sv
// Sequencing controller for the key-locked c499 core: serial key provisioning,
// operand issue over valid/ready, settle-timed capture and result return.
module c499_key_seq_ctrl #(
    parameter int DIN_W  = 41,
    parameter int DOUT_W = 32,
    parameter int KEY_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_sin,
    input  logic              key_sen,
    input  logic              key_commit,
    input  logic              key_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic [DIN_W-1:0]  core_in,
    output logic [KEY_W-1:0]  core_key,
    input  logic [DOUT_W-1:0] core_out,
    output logic              key_loaded,
    output logic              key_err,
    output logic              busy,
    output logic [15:0]       txn_count
);

    localparam int BITCNT_W = $clog2(KEY_W + 1);
    localparam logic [BITCNT_W-1:0] KEY_FULL = BITCNT_W'(KEY_W);
    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } stateType;

    stateType            state, stateNext;
    logic [KEY_W-1:0]    shadow, shadowNext;
    logic [BITCNT_W-1:0] bitCnt, bitCntNext;
    logic [3:0]          settleCnt, settleCntNext;
    logic [DIN_W-1:0]    coreIn, coreInNext;
    logic [KEY_W-1:0]    coreKey, coreKeyNext;
    logic [DOUT_W-1:0]   outData, outDataNext;
    logic                outValid, outValidNext;
    logic                keyLoaded, keyLoadedNext;
    logic                keyErr, keyErrNext;
    logic [15:0]         txnCount, txnCountNext;
    logic                inReady;
    logic                commitOk;

    assign inReady  = (state == IDLE) && keyLoaded;
    assign commitOk = (bitCnt == KEY_FULL) && (state == IDLE);

    assign in_ready   = inReady;
    assign out_valid  = outValid;
    assign out_data   = outData;
    assign core_in    = coreIn;
    assign core_key   = coreKey;
    assign key_loaded = keyLoaded;
    assign key_err    = keyErr;
    assign busy       = (state == WAIT) || (state == HOLD);
    assign txn_count  = txnCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            bitCnt    <= '0;
            settleCnt <= '0;
            coreIn    <= '0;
            coreKey   <= '0;
            outData   <= '0;
            outValid  <= 1'b0;
            keyLoaded <= 1'b0;
            keyErr    <= 1'b0;
            txnCount  <= '0;
        end else begin
            state     <= stateNext;
            shadow    <= shadowNext;
            bitCnt    <= bitCntNext;
            settleCnt <= settleCntNext;
            coreIn    <= coreInNext;
            coreKey   <= coreKeyNext;
            outData   <= outDataNext;
            outValid  <= outValidNext;
            keyLoaded <= keyLoadedNext;
            keyErr    <= keyErrNext;
            txnCount  <= txnCountNext;
        end
    end

    always_comb begin
        stateNext     = state;
        shadowNext    = shadow;
        bitCntNext    = bitCnt;
        settleCntNext = settleCnt;
        coreInNext    = coreIn;
        coreKeyNext   = coreKey;
        outDataNext   = outData;
        outValidNext  = outValid;
        keyLoadedNext = keyLoaded;
        keyErrNext    = keyErr;
        txnCountNext  = txnCount;

        if (key_clear) begin
            // Zeroise everything key-related and abort any transaction in flight.
            stateNext     = IDLE;
            shadowNext    = '0;
            bitCntNext    = '0;
            settleCntNext = '0;
            coreInNext    = '0;
            coreKeyNext   = '0;
            outValidNext  = 1'b0;
            keyLoadedNext = 1'b0;
            keyErrNext    = 1'b0;
        end else begin
            // A commit owns the cycle: a simultaneous shift bit is dropped.
            if (key_commit) begin
                if (commitOk) begin
                    coreKeyNext   = shadow;
                    keyLoadedNext = 1'b1;
                    bitCntNext    = '0;
                end else begin
                    keyErrNext = 1'b1;
                end
            end else if (key_sen) begin
                shadowNext = {shadow[KEY_W-2:0], key_sin};
                if (bitCnt != KEY_FULL) begin
                    bitCntNext = bitCnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid && inReady) begin
                        coreInNext    = in_data;
                        settleCntNext = SETTLE_CNT;
                        stateNext     = WAIT;
                    end
                end
                WAIT: begin
                    settleCntNext = settleCnt - 4'd1;
                    if (settleCnt == 4'd1) begin
                        outDataNext  = core_out;
                        outValidNext = 1'b1;
                        stateNext    = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValidNext = 1'b0;
                        txnCountNext = txnCount + 16'd1;
                        stateNext    = IDLE;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c499_key_seq_ctrl.sv
// Self-checking bench for c499_key_seq_ctrl: a behavioural key-locked core
// stand-in feeds core_out, and a result scoreboard checks every returned word.
module tb_c499_key_seq_ctrl;

    localparam int DIN_W  = 41;
    localparam int DOUT_W = 32;
    localparam int KEY_W  = 32;
    localparam int SETTLE = 2;
    localparam logic [31:0] GOOD_KEY = 32'hA5A50F0F;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_sin, key_sen, key_commit, key_clear;
    logic              in_valid, in_ready;
    logic [DIN_W-1:0]  in_data;
    logic              out_valid, out_ready;
    logic [DOUT_W-1:0] out_data;
    logic [DIN_W-1:0]  core_in;
    logic [KEY_W-1:0]  core_key;
    logic [DOUT_W-1:0] core_out;
    logic              key_loaded, key_err, busy;
    logic [15:0]       txn_count;

    int checkCnt = 0;
    int passCnt  = 0;
    logic [31:0] expQ[$];

    always #5 clk = ~clk;

    c499_key_seq_ctrl #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .KEY_W(KEY_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst),
        .key_sin(key_sin), .key_sen(key_sen), .key_commit(key_commit), .key_clear(key_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_in(core_in), .core_key(core_key), .core_out(core_out),
        .key_loaded(key_loaded), .key_err(key_err), .busy(busy), .txn_count(txn_count)
    );

    // Key-locked core stand-in: only GOOD_KEY yields the unscrambled
    // error-correcting behaviour; any other key corrupts the result.
    function automatic logic [31:0] coreModel(input logic [40:0] d, input logic [31:0] k);
        logic [31:0] synd;
        synd = {4{d[39:32]}} & {32{d[40]}};
        return d[31:0] ^ synd ^ (k ^ GOOD_KEY) ^ 32'h1357_9BDF;
    endfunction

    assign core_out = coreModel(core_in, core_key);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Result monitor: a handshake completes on the coming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                logic [31:0] e;
                e = expQ.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
                $display("txn result: out_data=%h expected=%h", out_data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shiftKey(input logic [31:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            key_sen = 1'b1;
            key_sin = k[31-i];
            tick();
        end
        key_sen = 1'b0;
    endtask

    task automatic commitKey();
        key_commit = 1'b1;
        tick();
        key_commit = 1'b0;
    endtask

    task automatic sendOp(input logic [40:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept", 64'(in_ready), 64'd1);
        if (in_ready) expQ.push_back(coreModel(d, GOOD_KEY));
        tick();
        in_valid = 1'b0;
        $display("txn issue: in_data=%h", d);
    endtask

    task automatic waitOutValid(input int maxc);
        int n;
        n = 0;
        while (!out_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("result_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_in_ready"},   64'(in_ready),   64'd0);
        chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
        chk({tag, "_out_data"},   64'(out_data),   64'd0);
        chk({tag, "_core_in"},    64'(core_in),    64'd0);
        chk({tag, "_core_key"},   64'(core_key),   64'd0);
        chk({tag, "_key_loaded"}, 64'(key_loaded), 64'd0);
        chk({tag, "_key_err"},    64'(key_err),    64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_txn_count"},  64'(txn_count),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] op;
        logic [31:0] e;
        rst = 1'b1; key_sin = 1'b0; key_sen = 1'b0; key_commit = 1'b0; key_clear = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b0;
        tick();

        // Operands are refused while locked.
        in_data  = 41'h1_0000_0001;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("locked_in_ready", 64'(in_ready), 64'd0);
            chk("locked_busy",     64'(busy),     64'd0);
        end
        in_valid = 1'b0;

        // Good provisioning.
        shiftKey(GOOD_KEY, 32);
        commitKey();
        chk("commit_core_key",   64'(core_key),   64'(GOOD_KEY));
        chk("commit_key_loaded", 64'(key_loaded), 64'd1);
        chk("commit_key_err",    64'(key_err),    64'd0);
        chk("commit_in_ready",   64'(in_ready),   64'd1);

        // Clear, then a short commit is refused and flagged.
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clear_key_loaded", 64'(key_loaded), 64'd0);
        chk("clear_core_key",   64'(core_key),   64'd0);
        shiftKey(GOOD_KEY, 31);
        commitKey();
        chk("short_key_err",    64'(key_err),    64'd1);
        chk("short_key_loaded", 64'(key_loaded), 64'd0);
        chk("short_core_key",   64'(core_key),   64'd0);
        shiftKey(GOOD_KEY, 32);
        commitKey();
        chk("reload_core_key",   64'(core_key),   64'(GOOD_KEY));
        chk("reload_key_loaded", 64'(key_loaded), 64'd1);
        chk("reload_key_err",    64'(key_err),    64'd1);

        // First transaction: latency and in_ready profile.
        out_ready = 1'b1;
        op = 41'h0_1234_5678;
        sendOp(op);
        chk("e0_out_valid", 64'(out_valid), 64'd0);
        chk("e0_in_ready",  64'(in_ready),  64'd0);
        chk("e0_busy",      64'(busy),      64'd1);
        chk("e0_core_in",   64'(core_in),   64'(op));
        tick();
        chk("e1_out_valid", 64'(out_valid), 64'd0);
        chk("e1_in_ready",  64'(in_ready),  64'd0);
        tick();
        chk("e2_out_valid", 64'(out_valid), 64'd1);
        chk("e2_in_ready",  64'(in_ready),  64'd0);
        chk("e2_out_data",  64'(out_data),  64'(coreModel(op, GOOD_KEY)));
        tick();
        chk("e3_out_valid", 64'(out_valid), 64'd0);
        chk("e3_in_ready",  64'(in_ready),  64'd1);
        chk("e3_txn_count", 64'(txn_count), 64'd1);

        // Random operands, including syndrome-enabled ones.
        for (int i = 0; i < 6; i++) begin
            op = 41'({$urandom(), $urandom()});
            sendOp(op);
            waitOutValid(10);
            tick();
        end
        chk("rand_txn_count", 64'(txn_count), 64'd7);
        chk("rand_sb_empty",  64'(expQ.size()), 64'd0);

        // Downstream stall in HOLD.
        out_ready = 1'b0;
        op = 41'h1_F0AA_55C3;
        e  = coreModel(op, GOOD_KEY);
        sendOp(op);
        waitOutValid(10);
        in_data  = 41'h0_DEAD_BEEF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_data",  64'(out_data),  64'(e));
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready",  64'(in_ready),  64'd0);
            chk("hold_core_in",   64'(core_in),   64'(op));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", 64'(out_valid), 64'd0);
        chk("hold_txn_count",     64'(txn_count), 64'd8);
        tick();
        chk("hold_txn_once",      64'(txn_count), 64'd8);

        // key_clear during WAIT aborts the transaction.
        op = 41'h0_0F0F_F0F0;
        sendOp(op);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        void'(expQ.pop_back());
        chk("abort_key_loaded", 64'(key_loaded), 64'd0);
        chk("abort_core_key",   64'(core_key),   64'd0);
        chk("abort_core_in",    64'(core_in),    64'd0);
        chk("abort_key_err",    64'(key_err),    64'd0);
        chk("abort_txn_count",  64'(txn_count),  64'd8);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_out_valid", 64'(out_valid), 64'd0);
            chk("abort_in_ready",  64'(in_ready),  64'd0);
            chk("abort_busy",      64'(busy),      64'd0);
            tick();
        end
        in_valid = 1'b0;

        // Re-provision, then exercise the counter wrap.
        shiftKey(GOOD_KEY, 32);
        commitKey();
        chk("reprov_key_loaded", 64'(key_loaded), 64'd1);
        force dut.txnCount = 16'hFFFF;
        tick();
        release dut.txnCount;
        chk("preload_txn_count", 64'(txn_count), 64'hFFFF);
        op = 41'h1_8001_7FFE;
        sendOp(op);
        waitOutValid(10);
        tick();
        chk("wrap_txn_count", 64'(txn_count), 64'd0);

        // Asynchronous reset in the middle of HOLD.
        out_ready = 1'b0;
        op = 41'h0_2468_ACE0;
        sendOp(op);
        waitOutValid(10);
        void'(expQ.pop_front());
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
